// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic light controller: state codes, lamp patterns
// and small elaboration helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    PED_WALK    = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALL_RED_B   = 3'd6,
    FLASH       = 3'd7
  } state_t;

  // Lamp bundles are {red, yellow, green}.
  typedef logic [2:0] light_t;

  localparam light_t RED    = 3'b100;
  localparam light_t YELLOW = 3'b010;
  localparam light_t GREEN  = 3'b001;
  localparam light_t OFF    = 3'b000;

  localparam int unsigned SEC_W = 8;

  function automatic bit dur_ok(input int unsigned d);
    return (d >= 1) && (d <= 255);
  endfunction

  // A single-tick second still needs a one-bit prescaler.
  function automatic int unsigned presc_width(input int unsigned ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

  function automatic light_t flash_lamp(input logic on);
    return on ? YELLOW : OFF;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Sensor inputs and lamp outputs of the intersection controller.
interface traffic_light_ctrl_if;
  import traffic_pkg::*;

  logic   side_sensor;
  logic   ped_req;
  logic   night_mode;
  light_t main_light;
  light_t side_light;
  logic   walk;
  logic   ped_ack;
  logic [2:0] state_o;

  modport master (
    output side_sensor, ped_req, night_mode,
    input  main_light, side_light, walk, ped_ack, state_o
  );

  modport slave (
    input  side_sensor, ped_req, night_mode,
    output main_light, side_light, walk, ped_ack, state_o
  );

endinterface

// File: rtl/traffic_light_ctrl_sec_timer.sv
// Prescaler plus seconds counter; expire is high on the last cycle of a dur-second
// interval, and load restarts the interval from zero.
module sec_timer
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_S = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [SEC_W-1:0] dur,
  output logic             expire
);

  localparam int unsigned     PW         = presc_width(TICKS_PER_S);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_S - 1);

  logic [PW-1:0]    presc_reg, presc_next;
  logic [SEC_W-1:0] sec_reg, sec_next;
  logic             wrap;

  assign wrap   = (presc_reg == PRESC_LAST);
  assign expire = wrap && (sec_reg == (dur - SEC_W'(1)));

  always_comb begin
    presc_next = presc_reg;
    sec_next   = sec_reg;
    if (load) begin
      presc_next = '0;
      sec_next   = '0;
    end else if (wrap) begin
      presc_next = '0;
      sec_next   = sec_reg + SEC_W'(1);
    end else begin
      presc_next = presc_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      sec_reg   <= '0;
    end else begin
      presc_reg <= presc_next;
      sec_reg   <= sec_next;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Four-way intersection controller: main/side road phases, pedestrian walk phase
// and night flashing, sequenced by a seconds timer.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICKS_PER_S = 50_000_000,
  parameter int unsigned GREEN_S     = 20,
  parameter int unsigned SIDE_S      = 10,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned ALLRED_S    = 1,
  parameter int unsigned WALK_S      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  io
);

  localparam logic [4:0][31:0] DURS = {32'(GREEN_S), 32'(SIDE_S), 32'(YELLOW_S),
                                       32'(ALLRED_S), 32'(WALK_S)};

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_dur_check
      if (!dur_ok(DURS[gi])) begin : g_bad_dur
        $error("traffic_light_ctrl: every phase duration must lie in 1..255 seconds");
      end
    end
    if (TICKS_PER_S < 1) begin : g_bad_ticks
      $error("traffic_light_ctrl: TICKS_PER_S must be at least 1");
    end
  endgenerate

  localparam logic [SEC_W-1:0] GREEN_D  = SEC_W'(GREEN_S);
  localparam logic [SEC_W-1:0] SIDE_D   = SEC_W'(SIDE_S);
  localparam logic [SEC_W-1:0] YELLOW_D = SEC_W'(YELLOW_S);
  localparam logic [SEC_W-1:0] ALLRED_D = SEC_W'(ALLRED_S);
  localparam logic [SEC_W-1:0] WALK_D   = SEC_W'(WALK_S);
  localparam logic [SEC_W-1:0] FLASH_D  = SEC_W'(1);

  state_t           state_reg, state_next;
  logic             ped_pending_reg, ped_pending_next;
  logic             flash_phase_reg, flash_phase_next;
  logic             ped_ack_reg, ped_ack_next;
  logic             expire;
  logic             timer_load;
  logic             ped_set;
  logic [SEC_W-1:0] dur;

  // Every expiry either changes state or re-arms the current one, so the
  // timer is restarted on exactly those cycles.
  assign timer_load = expire;

  sec_timer #(
    .TICKS_PER_S (TICKS_PER_S)
  ) u_sec_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .dur    (dur),
    .expire (expire)
  );

  always_comb begin
    dur = ALLRED_D;
    case (state_reg)
      MAIN_GREEN:  dur = GREEN_D;
      MAIN_YELLOW: dur = YELLOW_D;
      ALL_RED_A:   dur = ALLRED_D;
      PED_WALK:    dur = WALK_D;
      SIDE_GREEN:  dur = SIDE_D;
      SIDE_YELLOW: dur = YELLOW_D;
      ALL_RED_B:   dur = ALLRED_D;
      FLASH:       dur = FLASH_D;
      default:     dur = ALLRED_D;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    flash_phase_next = flash_phase_reg;
    if (expire) begin
      case (state_reg)
        MAIN_GREEN:  state_next = (ped_pending_reg || io.side_sensor) ? MAIN_YELLOW : MAIN_GREEN;
        MAIN_YELLOW: state_next = ALL_RED_A;
        ALL_RED_A:   state_next = ped_pending_reg ? PED_WALK : SIDE_GREEN;
        PED_WALK:    state_next = io.side_sensor ? SIDE_GREEN : ALL_RED_B;
        SIDE_GREEN:  state_next = SIDE_YELLOW;
        SIDE_YELLOW: state_next = ALL_RED_B;
        ALL_RED_B:   state_next = io.night_mode ? FLASH : MAIN_GREEN;
        FLASH:       state_next = io.night_mode ? FLASH : ALL_RED_B;
        default:     state_next = ALL_RED_B;
      endcase
      // Flashing always starts dark; the phase is parked at 0 outside FLASH.
      flash_phase_next = (state_reg == FLASH && state_next == FLASH) ? ~flash_phase_reg : 1'b0;
    end
  end

  // The request latch is independent of the phase decision made this cycle,
  // which only ever sees the registered ped_pending.
  assign ped_set = io.ped_req && !ped_pending_reg && (state_reg != PED_WALK);

  always_comb begin
    ped_pending_next = ped_pending_reg;
    ped_ack_next     = ped_set;
    if (ped_set) begin
      ped_pending_next = 1'b1;
    end
    if (state_reg != PED_WALK && state_next == PED_WALK) begin
      ped_pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ALL_RED_B;
      ped_pending_reg <= 1'b0;
      flash_phase_reg <= 1'b0;
      ped_ack_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ped_pending_reg <= ped_pending_next;
      flash_phase_reg <= flash_phase_next;
      ped_ack_reg     <= ped_ack_next;
    end
  end

  always_comb begin
    io.main_light = RED;
    io.side_light = RED;
    io.walk       = 1'b0;
    case (state_reg)
      MAIN_GREEN:  io.main_light = GREEN;
      MAIN_YELLOW: io.main_light = YELLOW;
      SIDE_GREEN:  io.side_light = GREEN;
      SIDE_YELLOW: io.side_light = YELLOW;
      PED_WALK:    io.walk       = 1'b1;
      FLASH: begin
        io.main_light = flash_lamp(flash_phase_reg);
        io.side_light = flash_lamp(flash_phase_reg);
      end
      default: ;
    endcase
  end

  assign io.ped_ack = ped_ack_reg;
  assign io.state_o = state_reg;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: a phase-level reference model queues every expected output
// change, and a monitor matches each DUT output change against the queue.
module tb_traffic_light_ctrl;
  import traffic_pkg::*;

  localparam int T  = 10;
  localparam int G  = 20;
  localparam int S  = 10;
  localparam int Y  = 3;
  localparam int AR = 1;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic reset;

  traffic_light_ctrl_if tif();

  traffic_light_ctrl #(
    .TICKS_PER_S (T),
    .GREEN_S     (G),
    .SIDE_S      (S),
    .YELLOW_S    (Y),
    .ALLRED_S    (AR),
    .WALK_S      (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (tif.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          cyc;
    logic [10:0] vec;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;

  // Output vector: {state_o, main_light, side_light, walk, ped_ack}
  function automatic logic [10:0] vec_of(input state_t s, input bit fl, input bit ack);
    logic [2:0] mn;
    logic [2:0] sd;
    bit wk;
    mn = 3'b100;
    sd = 3'b100;
    wk = 1'b0;
    case (s)
      MAIN_GREEN:  mn = 3'b001;
      MAIN_YELLOW: mn = 3'b010;
      SIDE_GREEN:  sd = 3'b001;
      SIDE_YELLOW: sd = 3'b010;
      PED_WALK:    wk = 1'b1;
      FLASH: begin
        mn = {1'b0, fl, 1'b0};
        sd = {1'b0, fl, 1'b0};
      end
      default: ;
    endcase
    return {3'(s), mn, sd, wk, ack};
  endfunction

  function automatic int dur_cycles(input state_t s);
    case (s)
      MAIN_GREEN:              return G * T;
      MAIN_YELLOW, SIDE_YELLOW: return Y * T;
      PED_WALK:                return W * T;
      SIDE_GREEN:              return S * T;
      FLASH:                   return T;
      default:                 return AR * T;
    endcase
  endfunction

  // Reference model: current phase plus cycles left in it.
  state_t      m_state = ALL_RED_B;
  int          m_left  = AR * T;
  bit          m_pend  = 1'b0;
  bit          m_flash = 1'b0;
  bit          m_ack   = 1'b0;
  logic [10:0] m_last  = vec_of(ALL_RED_B, 1'b0, 1'b0);

  task automatic push_if_changed();
    logic [10:0] v;
    ev_t e;
    v = vec_of(m_state, m_flash, m_ack);
    if (v != m_last) begin
      if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == cyc) begin
        exp_q[exp_q.size()-1].vec = v;
      end else begin
        e.cyc = cyc;
        e.vec = v;
        exp_q.push_back(e);
      end
      m_last = v;
    end
  endtask

  task automatic model_step();
    state_t nxt;
    state_t old_state;
    bit     old_pend;
    if (reset) begin
      m_state = ALL_RED_B;
      m_left  = AR * T;
      m_pend  = 1'b0;
      m_flash = 1'b0;
      m_ack   = 1'b0;
    end else begin
      old_state = m_state;
      old_pend  = m_pend;
      m_ack     = 1'b0;
      if (m_left == 1) begin
        nxt = m_state;
        case (m_state)
          MAIN_GREEN:  nxt = (old_pend || tif.side_sensor) ? MAIN_YELLOW : MAIN_GREEN;
          MAIN_YELLOW: nxt = ALL_RED_A;
          ALL_RED_A:   nxt = old_pend ? PED_WALK : SIDE_GREEN;
          PED_WALK:    nxt = tif.side_sensor ? SIDE_GREEN : ALL_RED_B;
          SIDE_GREEN:  nxt = SIDE_YELLOW;
          SIDE_YELLOW: nxt = ALL_RED_B;
          ALL_RED_B:   nxt = tif.night_mode ? FLASH : MAIN_GREEN;
          FLASH:       nxt = tif.night_mode ? FLASH : ALL_RED_B;
          default:     nxt = ALL_RED_B;
        endcase
        m_flash = (old_state == FLASH && nxt == FLASH) ? !m_flash : 1'b0;
        m_state = nxt;
        m_left  = dur_cycles(nxt);
        if (nxt == PED_WALK) m_pend = 1'b0;
      end else begin
        m_left = m_left - 1;
      end
      if (tif.ped_req && !old_pend && old_state != PED_WALK) begin
        m_pend = 1'b1;
        m_ack  = 1'b1;
      end
    end
    push_if_changed();
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Monitor: every DUT output change must match the next queued expectation.
  logic [10:0] mon_last = vec_of(ALL_RED_B, 1'b0, 1'b0);

  initial forever begin
    logic [10:0] v;
    ev_t e;
    @(negedge clk);
    v = {tif.state_o, tif.main_light, tif.side_light, tif.walk, tif.ped_ack};
    if (v != mon_last) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%b required no change", cyc, v);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec != v) begin
          errors++;
          $display("FAIL output_event cyc=%0d got=%b required cyc=%0d vec=%b", cyc, v, e.cyc, e.vec);
        end else begin
          $display("event cyc=%0d state=%0d main=%b side=%b walk=%b ack=%b",
                   cyc, v[10:8], v[7:5], v[4:2], v[1], v[0]);
        end
      end
      mon_last = v;
    end
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change cyc=%0d got=%b required vec=%b at cyc=%0d", cyc, v, e.vec, e.cyc);
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int maxc, input string tag);
    int n;
    n = 0;
    while (tif.state_o !== s && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (tif.state_o !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_%s state_o=%0d required %0d within %0d cycles", tag, tif.state_o, s, maxc);
    end
  endtask

  initial begin
    int ped_cnt;
    logic [10:0] rv;
    tif.side_sensor = 1'b0;
    tif.ped_req     = 1'b0;
    tif.night_mode  = 1'b0;
    reset = 1'b1;
    #1;
    rv = {tif.state_o, tif.main_light, tif.side_light, tif.walk, tif.ped_ack};
    checks++;
    if (rv !== vec_of(ALL_RED_B, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL reset_state got=%b required %b", rv, vec_of(ALL_RED_B, 1'b0, 1'b0));
    end
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Idle: ALL_RED_B then repeated MAIN_GREEN restarts.
    tick(450);

    // Side demand held through full side cycles.
    tif.side_sensor = 1'b1;
    tick(500);
    tif.side_sensor = 1'b0;

    // Pedestrian request mid-green, then repeated presses during the walk.
    wait_state(MAIN_GREEN, 600, "main_green_ped");
    tick(50);
    tif.ped_req = 1'b1;
    tick(1);
    tif.ped_req = 1'b0;
    wait_state(PED_WALK, 600, "ped_walk");
    for (int i = 0; i < 3; i++) begin
      tick(20);
      tif.ped_req = 1'b1;
      tick(1);
      tif.ped_req = 1'b0;
    end
    wait_state(MAIN_GREEN, 400, "main_green_after_walk");
    tick(100);

    // Night mode raised during SIDE_GREEN, later dropped.
    tif.side_sensor = 1'b1;
    wait_state(SIDE_GREEN, 600, "side_green_night");
    tif.night_mode  = 1'b1;
    tif.side_sensor = 1'b0;
    wait_state(FLASH, 400, "flash");
    tick(65);
    tif.night_mode = 1'b0;
    wait_state(MAIN_GREEN, 100, "main_green_after_flash");
    tick(20);

    // Randomized traffic.
    ped_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) tif.side_sensor = ~tif.side_sensor;
      if ($urandom_range(0, 599) == 0) tif.night_mode = ~tif.night_mode;
      if (ped_cnt > 0) begin
        ped_cnt--;
      end else begin
        tif.ped_req = 1'b0;
        if ($urandom_range(0, 39) == 0) begin
          tif.ped_req = 1'b1;
          ped_cnt = int'($urandom_range(0, 4));
        end
      end
    end
    @(negedge clk);
    tif.ped_req     = 1'b0;
    tif.night_mode  = 1'b0;
    tif.side_sensor = 1'b1;

    // Reset pulse during MAIN_YELLOW: lamps must go red at once.
    wait_state(MAIN_YELLOW, 800, "main_yellow_reset");
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tif.main_light !== 3'b100 || tif.side_light !== 3'b100 || tif.walk !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_lamps main=%b side=%b walk=%b required 100/100/0",
               tif.main_light, tif.side_light, tif.walk);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    tif.side_sensor = 1'b0;
    tick(400);

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

- Four-way intersection controller: main road, side road and pedestrian crossing.
- Sequences the light phases with an internal seconds timer.
- Registers pedestrian requests and vehicle sensor demand, and supports a night flashing mode.
- Top-level block of the traffic light controller; drives the lamp outputs directly.

## Interface
- TICKS_PER_S, 50_000_000: clock cycles per second (simulation uses 10)
- GREEN_S, 20: main green dwell, seconds
- SIDE_S, 10: side green dwell, seconds
- YELLOW_S, 3: yellow dwell, seconds
- ALLRED_S, 1: all-red clearance, seconds
- WALK_S, 8: pedestrian walk dwell, seconds
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- side_sensor  in  1  vehicle waiting on side road, level
- ped_req  in  1  pedestrian button, any-length pulse
- night_mode  in  1  request flashing-yellow operation, level
- main_light  out  3  {red, yellow, green} for main road
- side_light  out  3  {red, yellow, green} for side road
- walk  out  1  pedestrian walk lamp
- ped_ack  out  1  one-cycle pulse when a request is latched
- state_o  out  3  current state code (debug)

## Operation
- States: MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, PED_WALK, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, FLASH.
- Outputs are a pure decode of the state register:
  - Red is 3'b100; green and yellow light only the named road; every other lamp is red.
  - PED_WALK: both roads red, walk=1.
  - FLASH: both yellow bits = flash_phase, red and green 0.
- Transitions on timer expiry:
  - MAIN_GREEN: to MAIN_YELLOW if ped_pending or side_sensor is set at expiry; otherwise restart MAIN_GREEN (timer reloads).
  - MAIN_YELLOW to ALL_RED_A.
  - ALL_RED_A: to PED_WALK if ped_pending, else SIDE_GREEN.
  - PED_WALK: to SIDE_GREEN if side_sensor, else ALL_RED_B.
  - SIDE_GREEN to SIDE_YELLOW; SIDE_YELLOW to ALL_RED_B.
  - ALL_RED_B: to FLASH if night_mode, else MAIN_GREEN.
  - FLASH: flash_phase toggles every second. At each second boundary with night_mode=0, go to ALL_RED_B.
- ped_pending:
  - Set when ped_req=1 and ped_pending=0 and state is not PED_WALK; ped_ack pulses on that same set edge.
  - Cleared on entry to PED_WALK.
  - Requests during PED_WALK are ignored, with no ack.
- night_mode is only acted on at ALL_RED_B expiry. A request arriving mid-cycle completes the normal sequence first.

## Timing
- Reset values:
  - state ALL_RED_B, timer cleared, ped_pending 0, flash_phase 0.
  - main_light and side_light 3'b100, walk 0, ped_ack 0, state_o ALL_RED_B code.
- Timer: the prescaler counts 0..TICKS_PER_S-1 and the seconds counter increments on wrap. Expiry is the cycle where the seconds count reaches the state's duration and the prescaler wraps.
- State dwell is exactly duration×TICKS_PER_S cycles, then the state changes on the next rising edge. Prescaler and seconds counter clear on every state entry, including a MAIN_GREEN restart.
- FLASH uses a 1-second duration, re-armed every second.
- First MAIN_GREEN after reset release: ALLRED_S×TICKS_PER_S cycles.
- ped_req and expiry in the same cycle: the request is latched but not seen by that cycle's decision. Decisions use registered ped_pending.
- Reset asserted mid-phase: all lamps go red immediately (asynchronous) and the sequence restarts from ALL_RED_B.
- Seconds counter is 8 bits and the prescaler is $clog2(TICKS_PER_S) bits. Durations must be 1..255; elaboration fails on 0.

## Structure
- traffic_pkg holds:
  - the state encoding constants (3-bit);
  - light encodings RED=3'b100, YELLOW=3'b010, GREEN=3'b001, OFF=3'b000.
- Sub-module sec_timer contains the prescaler and seconds counter.
  - Ports: clk, reset, load, dur[7:0], expire.
  - load clears both counters; expire is combinational on the final cycle.
- The top level holds the state register, next-state logic, ped latch and output decode.

## Test plan
All scenarios use TICKS_PER_S=10 and default durations.
- Reset release, no inputs:
  - ALL_RED_B for 10 cycles, then MAIN_GREEN with main_light=001 and side_light=100.
  - MAIN_GREEN restarts every 200 cycles indefinitely.
- side_sensor=1 held: sequence MAIN_GREEN 200, MAIN_YELLOW 30, ALL_RED_A 10, SIDE_GREEN 100, SIDE_YELLOW 30, ALL_RED_B 10, then MAIN_GREEN.
- 1-cycle ped_req 50 cycles into MAIN_GREEN:
  - ped_ack pulses once, on the next cycle.
  - After ALL_RED_A comes PED_WALK, walk=1 for 80 cycles, then ALL_RED_B.
- ped_req repeated during PED_WALK: no ped_ack and no second walk phase.
- night_mode=1 during SIDE_GREEN:
  - Sequence completes to ALL_RED_B, then FLASH with both yellow bits toggling every 10 cycles.
  - Dropping night_mode leads to ALL_RED_B within 10 cycles.
- Reset pulsed during MAIN_YELLOW: lamps read 100/100 in the same cycle, and the state restarts at ALL_RED_B.
